// File: rtl/retire_scoreboard.sv
// retire_scoreboard: in-order FIFO of expected retire events checked against actual MEM/WB events, with counters and first-error capture
module retire_scoreboard #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int IGNORE_X0   = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic                       exp_kind,
  input  logic [4:0]                 exp_tag,
  input  logic [XLEN-1:0]            exp_data,
  input  logic                       act_valid,
  input  logic                       act_kind,
  input  logic [4:0]                 act_tag,
  input  logic [XLEN-1:0]            act_data,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic [CNT_W-1:0]           underflow_cnt,
  output logic                       err_flag,
  output logic                       first_err_kind,
  output logic [4:0]                 first_err_tag,
  output logic [XLEN-1:0]            first_err_exp,
  output logic [XLEN-1:0]            first_err_act,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN+5:0] mem [DEPTH];
  logic [XLEN+5:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, drop, cmp, empty, pop, hit, bad, und, err;
  assign head      = mem[rd_ptr];
  assign empty     = fifo_count == '0;
  assign exp_ready = (fifo_count != CW'(DEPTH)) & ~halted;
  assign push      = exp_valid & exp_ready;
  assign drop      = (IGNORE_X0 != 0) & ~act_kind & (act_tag == 5'd0);
  assign cmp       = act_valid & ~halted & ~drop;
  assign pop       = cmp & ~empty;
  assign hit       = pop & (head == {act_kind, act_tag, act_data});
  assign bad       = pop & ~hit;
  assign und       = cmp & empty;
  assign err       = bad | und;
  always_ff @(posedge clk)
    state_q <= (rst | clr) ? RUN : state_d;
  always_comb
    state_d = (err && STOP_ON_ERR != 0) ? HALT : state_q;
  always_comb
    halted = state_q == HALT;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {exp_kind, exp_tag, exp_data};
  always_ff @(posedge clk) begin
    if (rst | clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      match_cnt      <= '0;
      mismatch_cnt   <= '0;
      underflow_cnt  <= '0;
      err_flag       <= 1'b0;
      first_err_kind <= 1'b0;
      first_err_tag  <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (hit && ~&match_cnt) match_cnt <= match_cnt + 1'b1;
      if (bad && ~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + 1'b1;
      if (und && ~&underflow_cnt) underflow_cnt <= underflow_cnt + 1'b1;
      if (err && !err_flag) begin
        err_flag       <= 1'b1;
        first_err_kind <= act_kind;
        first_err_tag  <= act_tag;
        first_err_exp  <= und ? '0 : head[XLEN-1:0];
        first_err_act  <= act_data;
      end
    end
  end
endmodule

// File: tb/tb_retire_scoreboard.sv
// tb_retire_scoreboard: directed vector table plus hand sequences for full/wrap, halt and mid-stream clear
module tb_retire_scoreboard;
  logic clk = 1'b0;
  logic rst, clr, ev, ek, av, ak;
  logic [4:0] et, at;
  logic [31:0] ed, ad;
  logic rdy, e, fk, hl;
  logic [15:0] m, mm, u;
  logic [4:0] ft;
  logic [31:0] fe, fa;
  logic [3:0] fc;
  logic h_rdy, h_e, h_fk, h_hl;
  logic [15:0] h_m, h_mm, h_u;
  logic [4:0] h_ft;
  logic [31:0] h_fe, h_fa;
  logic [3:0] h_fc;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  retire_scoreboard dut (
    .clk(clk), .rst(rst), .clr(clr),
    .exp_valid(ev), .exp_ready(rdy), .exp_kind(ek), .exp_tag(et), .exp_data(ed),
    .act_valid(av), .act_kind(ak), .act_tag(at), .act_data(ad),
    .match_cnt(m), .mismatch_cnt(mm), .underflow_cnt(u), .err_flag(e),
    .first_err_kind(fk), .first_err_tag(ft), .first_err_exp(fe), .first_err_act(fa),
    .fifo_count(fc), .halted(hl)
  );
  retire_scoreboard #(.STOP_ON_ERR(1)) dut_h (
    .clk(clk), .rst(rst), .clr(clr),
    .exp_valid(ev), .exp_ready(h_rdy), .exp_kind(ek), .exp_tag(et), .exp_data(ed),
    .act_valid(av), .act_kind(ak), .act_tag(at), .act_data(ad),
    .match_cnt(h_m), .mismatch_cnt(h_mm), .underflow_cnt(h_u), .err_flag(h_e),
    .first_err_kind(h_fk), .first_err_tag(h_ft), .first_err_exp(h_fe), .first_err_act(h_fa),
    .fifo_count(h_fc), .halted(h_hl)
  );
  typedef struct {
    logic clr, ev, ek; logic [4:0] et; logic [31:0] ed;
    logic av, ak; logic [4:0] at; logic [31:0] ad;
    int m, mm, u; logic e; int fc; logic rdy;
    logic [4:0] ftag; logic [31:0] fexp, fact; logic fkind;
  } vec_t;
  vec_t v[20];
  logic [37:0] q[$];
  logic [37:0] x, n;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] r);
    n_cmp++;
    if (a !== r) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, r);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    clr = 1'b0; ev = 1'b0; av = 1'b0;
  endtask
  task automatic push(input logic k, input logic [4:0] t, input logic [31:0] d);
    ev = 1'b1; ek = k; et = t; ed = d;
  endtask
  task automatic act(input logic k, input logic [4:0] t, input logic [31:0] d);
    av = 1'b1; ak = k; at = t; ad = d;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " match"}, m, 0);
    chk({nm, " mismatch"}, mm, 0);
    chk({nm, " underflow"}, u, 0);
    chk({nm, " err"}, e, 0);
    chk({nm, " fifo_count"}, fc, 0);
    chk({nm, " ready"}, rdy, 1);
    chk({nm, " halted"}, hl, 0);
    chk({nm, " ferr_kind"}, fk, 0);
    chk({nm, " ferr_tag"}, ft, 0);
    chk({nm, " ferr_exp"}, fe, 0);
    chk({nm, " ferr_act"}, fa, 0);
  endtask
  initial begin
    v[0]  = '{0,1,0,1,32'h5,        0,0,0,0,             0,0,0,0,1,1, 0,0,0,0};
    v[1]  = '{0,1,0,2,32'hA,        0,0,0,0,             0,0,0,0,2,1, 0,0,0,0};
    v[2]  = '{0,1,0,3,32'hFFFFFFFF, 0,0,0,0,             0,0,0,0,3,1, 0,0,0,0};
    v[3]  = '{0,1,0,4,32'h0,        0,0,0,0,             0,0,0,0,4,1, 0,0,0,0};
    v[4]  = '{0,0,0,0,0,            1,0,1,32'h5,         1,0,0,0,3,1, 0,0,0,0};
    v[5]  = '{0,0,0,0,0,            1,0,2,32'hA,         2,0,0,0,2,1, 0,0,0,0};
    v[6]  = '{0,0,0,0,0,            1,0,3,32'hFFFFFFFF,  3,0,0,0,1,1, 0,0,0,0};
    v[7]  = '{0,0,0,0,0,            1,0,4,32'h0,         4,0,0,0,0,1, 0,0,0,0};
    v[8]  = '{0,1,0,5,32'h10,       0,0,0,0,             4,0,0,0,1,1, 0,0,0,0};
    v[9]  = '{0,0,0,0,0,            1,0,5,32'h11,        4,1,0,1,0,1, 5,32'h10,32'h11,0};
    v[10] = '{0,1,0,7,32'h20,       0,0,0,0,             4,1,0,1,1,1, 5,32'h10,32'h11,0};
    v[11] = '{0,0,0,0,0,            1,1,3,32'h20,        4,2,0,1,0,1, 5,32'h10,32'h11,0};
    v[12] = '{1,1,0,9,32'h9,        1,0,9,32'h9,         0,0,0,0,0,1, 0,0,0,0};
    v[13] = '{0,1,0,6,32'h1,        1,0,6,32'h1,         0,0,1,1,1,1, 6,0,32'h1,0};
    v[14] = '{0,0,0,0,0,            1,0,6,32'h1,         1,0,1,1,0,1, 6,0,32'h1,0};
    v[15] = '{0,0,0,0,0,            1,0,0,32'h7,         1,0,1,1,0,1, 6,0,32'h1,0};
    v[16] = '{0,1,0,8,32'h9,        0,0,0,0,             1,0,1,1,1,1, 6,0,32'h1,0};
    v[17] = '{0,0,0,0,0,            1,0,0,32'h7,         1,0,1,1,1,1, 6,0,32'h1,0};
    v[18] = '{0,0,0,0,0,            1,0,8,32'h9,         2,0,1,1,0,1, 6,0,32'h1,0};
    v[19] = '{0,0,0,0,0,            1,1,0,32'h7,         2,0,2,1,0,1, 6,0,32'h1,0};
    rst = 1'b1; clr = 1'b0; ev = 1'b0; ek = 1'b0; et = '0; ed = '0;
    av = 1'b0; ak = 1'b0; at = '0; ad = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");
    for (int i = 0; i < 20; i++) begin
      clr = v[i].clr; ev = v[i].ev; ek = v[i].ek; et = v[i].et; ed = v[i].ed;
      av = v[i].av; ak = v[i].ak; at = v[i].at; ad = v[i].ad;
      step();
      chk($sformatf("v%0d match", i), m, v[i].m);
      chk($sformatf("v%0d mismatch", i), mm, v[i].mm);
      chk($sformatf("v%0d underflow", i), u, v[i].u);
      chk($sformatf("v%0d err", i), e, v[i].e);
      chk($sformatf("v%0d fifo_count", i), fc, v[i].fc);
      chk($sformatf("v%0d ready", i), rdy, v[i].rdy);
      chk($sformatf("v%0d ferr_tag", i), ft, v[i].ftag);
      chk($sformatf("v%0d ferr_exp", i), fe, v[i].fexp);
      chk($sformatf("v%0d ferr_act", i), fa, v[i].fact);
      chk($sformatf("v%0d ferr_kind", i), fk, v[i].fkind);
    end
    clr = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      n = {1'b0, 5'(i + 1), 32'h100 + 32'(i)};
      push(n[37], n[36:32], n[31:0]);
      q.push_back(n);
      step();
    end
    chk("full fifo_count", fc, 8);
    chk("full ready", rdy, 0);
    push(1'b0, 5'd30, 32'hDEAD);
    step();
    chk("full extra push fifo_count", fc, 8);
    x = q.pop_front();
    act(x[37], x[36:32], x[31:0]);
    step();
    chk("pop from full match", m, 1);
    chk("pop from full fifo_count", fc, 7);
    chk("pop from full ready", rdy, 1);
    for (int k = 0; k < 24; k++) begin
      x = q.pop_front();
      act(x[37], x[36:32], x[31:0]);
      n = {1'(k % 2), 5'((k % 31) + 1), 32'hA5000000 ^ 32'(k * 7919)};
      push(n[37], n[36:32], n[31:0]);
      q.push_back(n);
      step();
      chk($sformatf("wrap%0d fifo_count", k), fc, 7);
      chk($sformatf("wrap%0d match", k), m, 2 + k);
    end
    chk("wrap mismatch", mm, 0);
    chk("wrap err", e, 0);
    clr = 1'b1;
    step();
    push(1'b1, 5'd10, 32'hAB);
    step();
    act(1'b1, 5'd10, 32'hAC);
    step();
    chk("halt halted", h_hl, 1);
    chk("halt ready", h_rdy, 0);
    chk("halt mismatch", h_mm, 1);
    chk("halt ferr_kind", h_fk, 1);
    chk("nohalt halted", hl, 0);
    push(1'b0, 5'd1, 32'h1);
    act(1'b0, 5'd1, 32'h1);
    step();
    chk("halt frozen fifo_count", h_fc, 0);
    chk("halt frozen underflow", h_u, 0);
    chk("nohalt underflow", u, 1);
    chk("nohalt fifo_count", fc, 1);
    act(1'b0, 5'd1, 32'h1);
    step();
    chk("halt frozen match", h_m, 0);
    chk("halt frozen underflow2", h_u, 0);
    chk("nohalt match", m, 1);
    for (int i = 2; i < 5; i++) begin
      push(1'b0, 5'(i), 32'(i));
      step();
    end
    chk("midclr fifo_count before", fc, 3);
    chk("midclr err before", e, 1);
    clr = 1'b1;
    step();
    chk_reset("midclr");
    chk("midclr halt released", h_hl, 0);
    chk("midclr halt ready", h_rdy, 1);
    push(1'b0, 5'd9, 32'h5);
    step();
    act(1'b0, 5'd9, 32'h5);
    step();
    chk("after clr match", m, 1);
    chk("after clr mismatch", mm, 0);
    chk("after clr fifo_count", fc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
